// File: rtl/kuznechik_key_expander_if.sv
// Key-load handshake and round-key write port between the expander and its consumer.
// The slave modport is the expander; the master modport is the requester and key-memory side.
interface kuznechik_key_expander_if #(
  parameter int KEY_ADDR_W = 4
);
  logic                  request_i;
  logic                  ack_i;
  logic [255:0]          key_i;
  logic                  busy_o;
  logic                  valid_o;
  logic                  key_we_o;
  logic [KEY_ADDR_W-1:0] key_addr_o;
  logic [127:0]          key_data_o;

  modport master (
    output request_i, ack_i, key_i,
    input  busy_o, valid_o, key_we_o, key_addr_o, key_data_o
  );

  modport slave (
    input  request_i, ack_i, key_i,
    output busy_o, valid_o, key_we_o, key_addr_o, key_data_o
  );
endinterface

// File: rtl/kuznechik_key_expander.sv
// Kuznechik master-key expansion into K1..K10, one registered write per key (1130 cycles per request).
// No backpressure: requests are ignored while busy, and valid_o holds until ack_i or a new request.
module kuznechik_key_expander #(
  parameter int KEY_ADDR_W = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  kuznechik_key_expander_if.slave  kx
);

  typedef enum logic [3:0] {
    IDLE, WR_K1, WR_K2, CGEN, KX, KS, KL, FEIST, WR_A, WR_B, DONE
  } state_t;

  localparam logic [0:15][7:0] LCOEF = {
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  localparam logic [0:255][7:0] SBOX = {
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  // GF(2^8) modulo x^8 + x^7 + x^6 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] r_step(input logic [127:0] x);
    logic [7:0] acc;
    acc = 8'h00;
    for (int k = 0; k < 16; k++) acc = acc ^ gf_mul(x[127-8*k -: 8], LCOEF[k]);
    return {acc, x[127:8]};
  endfunction

  function automatic logic [127:0] s_layer(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int k = 0; k < 16; k++) y[8*k +: 8] = SBOX[x[8*k +: 8]];
    return y;
  endfunction

  state_t                state, state_n;
  logic [127:0]          a1, a1_n, a0, a0_n, c, c_n, t, t_n;
  logic [5:0]            iter, iter_n;
  logic [3:0]            step, step_n;
  logic                  valid_q, valid_n, we_q, we_n;
  logic [KEY_ADDR_W-1:0] addr_q, addr_n;
  logic [127:0]          data_q, data_n;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      a1      <= '0;
      a0      <= '0;
      c       <= '0;
      t       <= '0;
      iter    <= '0;
      step    <= '0;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state   <= state_n;
      a1      <= a1_n;
      a0      <= a0_n;
      c       <= c_n;
      t       <= t_n;
      iter    <= iter_n;
      step    <= step_n;
      valid_q <= valid_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      data_q  <= data_n;
    end
  end

  // Write strobe, address and data are computed for the state being entered so the
  // registered port lines up with the write state itself.
  always_comb begin
    state_n = state;
    a1_n    = a1;
    a0_n    = a0;
    c_n     = c;
    t_n     = t;
    iter_n  = iter;
    step_n  = step;
    valid_n = valid_q;
    we_n    = 1'b0;
    addr_n  = addr_q;
    data_n  = data_q;
    case (state)
      IDLE, DONE: begin
        if (state == DONE && kx.ack_i) valid_n = 1'b0;
        if (kx.request_i) begin
          a1_n    = kx.key_i[255:128];
          a0_n    = kx.key_i[127:0];
          iter_n  = 6'd1;
          valid_n = 1'b0;
          state_n = WR_K1;
          we_n    = 1'b1;
          addr_n  = '0;
          data_n  = kx.key_i[255:128];
        end
      end
      WR_K1: begin
        state_n = WR_K2;
        we_n    = 1'b1;
        addr_n  = KEY_ADDR_W'(1);
        data_n  = a0;
      end
      WR_K2: begin
        state_n = CGEN;
        t_n     = {122'd0, iter};
      end
      CGEN, KL: begin
        t_n    = r_step(t);
        step_n = step + 4'd1;
        if (step == 4'd15) begin
          if (state == CGEN) begin
            c_n     = t_n;
            state_n = KX;
          end else begin
            state_n = FEIST;
          end
        end
      end
      KX: begin
        t_n     = a1 ^ c;
        state_n = KS;
      end
      KS: begin
        t_n     = s_layer(t);
        state_n = KL;
      end
      FEIST: begin
        a1_n   = t ^ a0;
        a0_n   = a1;
        iter_n = iter + 6'd1;
        if (iter[2:0] != 3'd0) begin
          state_n = CGEN;
          t_n     = {122'd0, iter_n};
        end else begin
          state_n = WR_A;
          we_n    = 1'b1;
          addr_n  = KEY_ADDR_W'({iter_n[5:3], 1'b0});
          data_n  = a1_n;
        end
      end
      WR_A: begin
        state_n = WR_B;
        we_n    = 1'b1;
        addr_n  = addr_q + KEY_ADDR_W'(1);
        data_n  = a0;
      end
      WR_B: begin
        if (iter == 6'd33) begin
          state_n = DONE;
          valid_n = 1'b1;
        end else begin
          state_n = CGEN;
          t_n     = {122'd0, iter};
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign kx.busy_o     = (state != IDLE) && (state != DONE);
  assign kx.valid_o    = valid_q;
  assign kx.key_we_o   = we_q;
  assign kx.key_addr_o = addr_q;
  assign kx.key_data_o = data_q;

endmodule

// File: tb/tb_kuznechik_key_expander.sv
// Directed bench for kuznechik_key_expander using the GOST R 34.12-2015 key schedule example.
module tb_kuznechik_key_expander;

  localparam logic [255:0] GOST_KEY  = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [255:0] OTHER_KEY = 256'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef;
  localparam logic [127:0] C1        = 128'h6ea276726c487ab85d27bd10dd849401;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kuznechik_key_expander_if #(.KEY_ADDR_W(4)) bus ();

  kuznechik_key_expander #(.KEY_ADDR_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .kx    (bus)
  );

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write log, sampled just after each rising edge
  int           nw = 0;
  logic [3:0]   wr_addr [0:63];
  logic [127:0] wr_data [0:63];
  int           wr_cyc  [0:63];
  int           base    = 0;

  always @(posedge clk) begin
    #1;
    if (bus.key_we_o && nw < 64) begin
      wr_addr[nw] = bus.key_addr_o;
      wr_data[nw] = bus.key_data_o;
      wr_cyc[nw]  = cyc - base;
      nw = nw + 1;
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_check(input bit inject, input bit check_c);
    int start, first_valid, busy_bad, rel;
    int           wt [0:9];
    logic [127:0] kexp [0:9];
    bit           kchk [0:9];
    wt   = '{1, 2, 283, 284, 565, 566, 847, 848, 1129, 1130};
    kexp = '{128'h8899aabbccddeeff0011223344556677, 128'hfedcba98765432100123456789abcdef,
             128'hdb31485315694343228d6aef8cc78c44, 128'h3d4553d8e9cfec6815ebadc40a9ffd04,
             128'h0, 128'h0, 128'h0, 128'h0,
             128'hbb44e25378c73123a5f32f73cdb6e517, 128'h72e9dd7416bcf45b755dbaa88e4a4043};
    kchk = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    @(negedge clk);
    start = nw;
    base  = cyc;
    bus.key_i     = GOST_KEY;
    bus.request_i = 1'b1;
    @(negedge clk);
    bus.request_i = 1'b0;
    bus.key_i     = '0;
    first_valid = -1;
    busy_bad    = 0;
    for (int n = 0; n < 1200 && first_valid < 0; n++) begin
      rel = cyc - base;
      if (bus.valid_o) first_valid = rel;
      else if (!bus.busy_o) busy_bad++;
      if (check_c && rel == 25) check("c1", dut.c, C1);
      if (inject && rel == 499) begin
        bus.request_i = 1'b1;
        bus.key_i     = OTHER_KEY;
      end
      if (inject && rel == 500) begin
        bus.request_i = 1'b0;
        bus.key_i     = '0;
      end
      if (first_valid < 0) @(negedge clk);
    end
    check("valid_rise_cycle", first_valid, 1131);
    check("busy_gap_cycles", busy_bad, 0);
    check("busy_after_done", bus.busy_o, 1'b0);
    check("write_count", nw - start, 10);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("addr_%0d", k), wr_addr[start+k], k);
      check($sformatf("wcyc_%0d", k), wr_cyc[start+k], wt[k]);
      if (kchk[k]) check($sformatf("key_%0d", k + 1), wr_data[start+k], kexp[k]);
    end
  endtask

  initial begin
    int held_low;
    int after;
    rst           = 1'b1;
    bus.request_i = 1'b0;
    bus.ack_i     = 1'b0;
    bus.key_i     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_valid", bus.valid_o, 1'b0);
    check("rst_we", bus.key_we_o, 1'b0);
    check("rst_addr", bus.key_addr_o, 4'd0);
    check("rst_data", bus.key_data_o, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full vector, constant probe, and an ignored request mid-run
    run_check(1'b1, 1'b1);

    // valid_o holds without ack
    held_low = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!bus.valid_o) held_low++;
    end
    check("valid_hold_no_ack", held_low, 0);
    bus.ack_i = 1'b1;
    @(negedge clk);
    bus.ack_i = 1'b0;
    check("valid_after_ack", bus.valid_o, 1'b0);
    check("busy_after_ack", bus.busy_o, 1'b0);

    // request and ack together in DONE restarts expansion
    bus.request_i = 1'b1;
    bus.ack_i     = 1'b1;
    bus.key_i     = GOST_KEY;
    base          = cyc;
    @(negedge clk);
    bus.request_i = 1'b0;
    bus.ack_i     = 1'b0;
    bus.key_i     = '0;
    check("restart_valid", bus.valid_o, 1'b0);
    check("restart_busy", bus.busy_o, 1'b1);
    check("restart_we", bus.key_we_o, 1'b1);
    check("restart_addr", bus.key_addr_o, 4'd0);

    // reset mid-run
    while (cyc - base < 299) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", bus.busy_o, 1'b0);
    check("midrst_valid", bus.valid_o, 1'b0);
    check("midrst_we", bus.key_we_o, 1'b0);
    check("midrst_addr", bus.key_addr_o, 4'd0);
    check("midrst_data", bus.key_data_o, 128'd0);
    after = nw;
    repeat (400) @(negedge clk);
    check("no_writes_after_rst", nw - after, 0);
    check("idle_busy_after_rst", bus.busy_o, 1'b0);

    // a fresh request after the aborted run produces the full sequence
    run_check(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
